// File: rtl/param_clk_divider.sv
// Divides i_ref_clk by a runtime ratio; ratio, start and stop take effect only at period boundaries.
// Outputs are registered; a start request is answered with o_div_clk=1 and o_div_tick=1 on the next edge. No backpressure.
module param_clk_divider #(
  parameter int DIV_WIDTH     = 8,
  parameter bit DUTY_ROUND_UP = 1'b0
) (
  input  logic                 i_ref_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clk_en,
  input  logic [DIV_WIDTH-1:0] i_div_ratio,
  output logic                 o_div_clk,
  output logic                 o_div_tick,
  output logic                 o_active,
  output logic [DIV_WIDTH-1:0] o_ratio_cur
);

  localparam logic [DIV_WIDTH-1:0] ONE  = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] TWO  = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH:0]   ONE1 = (DIV_WIDTH+1)'(1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t               state;
  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] cnt_nxt;
  logic [DIV_WIDTH:0]   high_len;
  logic                 start_ok;
  logic                 boundary;

  // One extra bit keeps (R+1)>>1 exact for R = 2^DIV_WIDTH-1.
  assign high_len = DUTY_ROUND_UP ? (({1'b0, o_ratio_cur} + ONE1) >> 1)
                                  : ({1'b0, o_ratio_cur} >> 1);
  assign cnt_nxt  = cnt + ONE;
  assign start_ok = i_clk_en && (i_div_ratio >= TWO);
  assign boundary = (cnt == (o_ratio_cur - ONE));
  assign o_active = (state == RUN);

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      o_div_clk   <= 1'b0;
      o_div_tick  <= 1'b0;
      o_ratio_cur <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start_ok) begin
            state       <= RUN;
            o_ratio_cur <= i_div_ratio;
            o_div_clk   <= 1'b1;
            o_div_tick  <= 1'b1;
          end else begin
            o_div_clk  <= 1'b0;
            o_div_tick <= 1'b0;
          end
        end
        RUN: begin
          if (boundary) begin
            cnt <= '0;
            if (start_ok) begin
              o_ratio_cur <= i_div_ratio;
              o_div_clk   <= 1'b1;
              o_div_tick  <= 1'b1;
            end else begin
              state      <= IDLE;
              o_div_clk  <= 1'b0;
              o_div_tick <= 1'b0;
            end
          end else begin
            // cnt stays below R_cur-1 here, so the increment never wraps.
            cnt        <= cnt_nxt;
            o_div_clk  <= ({1'b0, cnt_nxt} < high_len);
            o_div_tick <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_clk_divider.sv
// Directed bench: two dividers (floor and ceil duty) share stimulus; patterns are compared as bit vectors.
module tb_param_clk_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [7:0] ratio = 8'd0;

  logic       dclk0, tick0, act0;
  logic [7:0] rcur0;
  logic       dclk1, tick1, act1;
  logic [7:0] rcur1;

  int n_cmp = 0;
  int n_err = 0;

  param_clk_divider #(.DIV_WIDTH(8), .DUTY_ROUND_UP(1'b0)) u_dut_floor (
    .i_ref_clk  (clk),
    .i_rst_n    (rst_n),
    .i_clk_en   (en),
    .i_div_ratio(ratio),
    .o_div_clk  (dclk0),
    .o_div_tick (tick0),
    .o_active   (act0),
    .o_ratio_cur(rcur0)
  );

  param_clk_divider #(.DIV_WIDTH(8), .DUTY_ROUND_UP(1'b1)) u_dut_ceil (
    .i_ref_clk  (clk),
    .i_rst_n    (rst_n),
    .i_clk_en   (en),
    .i_div_ratio(ratio),
    .o_div_clk  (dclk1),
    .o_div_tick (tick1),
    .o_active   (act1),
    .o_ratio_cur(rcur1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Samples the current cycle, then advances; returns MSB-first history.
  task automatic capture(input int n, output logic [15:0] c0, output logic [15:0] c1,
                         output logic [15:0] t0);
    c0 = '0; c1 = '0; t0 = '0;
    for (int i = 0; i < n; i++) begin
      c0 = {c0[14:0], dclk0};
      c1 = {c1[14:0], dclk1};
      t0 = {t0[14:0], tick0};
      step();
    end
  endtask

  task automatic sync_tick(input string tag, input int max);
    int k;
    k = 0;
    step();
    while (!tick0 && k < max) begin
      step();
      k++;
    end
    chk(tag, {31'd0, tick0}, 32'd1);
  endtask

  logic [15:0] c0, c1, t0;
  int hi0, hi1, len;

  initial begin
    // Reset state, forced asynchronously
    #2 rst_n = 1'b0;
    #1;
    chk("rst_clk",    {31'd0, dclk0}, 32'd0);
    chk("rst_tick",   {31'd0, tick0}, 32'd0);
    chk("rst_active", {31'd0, act0},  32'd0);
    chk("rst_ratio",  {24'd0, rcur0}, 32'd0);

    // Requests while in reset are ignored; release away from the edge
    en = 1'b1; ratio = 8'd4;
    step(); step();
    chk("rst_hold_active", {31'd0, act0}, 32'd0);
    rst_n = 1'b1;
    #2;
    chk("rel_no_change", {31'd0, act0}, 32'd0);
    step();
    chk("r4_start_tick",  {31'd0, tick0}, 32'd1);
    chk("r4_start_ratio", {24'd0, rcur0}, 32'd4);
    capture(8, c0, c1, t0);
    chk("r4_clk",    {24'd0, c0[7:0]}, 32'b11001100);
    chk("r4_tick",   {24'd0, t0[7:0]}, 32'b10001000);
    chk("r4_ceil",   {24'd0, c1[7:0]}, 32'b11001100);
    chk("r4_active", {31'd0, act0}, 32'd1);

    // Odd ratio duty in both rounding modes
    ratio = 8'd5;
    sync_tick("r5_sync", 10);
    chk("r5_ratio", {24'd0, rcur0}, 32'd5);
    capture(10, c0, c1, t0);
    chk("r5_floor", {22'd0, c0[9:0]}, 32'b1100011000);
    chk("r5_ceil",  {22'd0, c1[9:0]}, 32'b1110011100);
    chk("r5_tick",  {22'd0, t0[9:0]}, 32'b1000010000);

    // Ratio change at cnt=2 of a 6-period
    ratio = 8'd6;
    sync_tick("r6_sync", 10);
    capture(2, c0, c1, t0);
    chk("r6_head", {30'd0, c0[1:0]}, 32'b11);
    ratio = 8'd3;
    capture(3, c0, c1, t0);
    chk("r6_mid", {29'd0, c0[2:0]}, 32'b100);
    chk("r6_ratio_hold", {24'd0, rcur0}, 32'd6);
    capture(4, c0, c1, t0);
    chk("r6_to_r3_clk",  {28'd0, c0[3:0]}, 32'b0100);
    chk("r6_to_r3_tick", {28'd0, t0[3:0]}, 32'b0100);
    chk("r3_ratio",      {24'd0, rcur0}, 32'd3);
    chk("r3_ceil_head",  {28'd0, c1[3:0]}, 32'b0110);

    // Enable dropped at cnt=1 of an 8-period
    ratio = 8'd8;
    sync_tick("r8_sync", 10);
    capture(1, c0, c1, t0);
    en = 1'b0;
    capture(7, c1, c1, t0);
    chk("r8_period", {24'd0, c0[0], c1[6:0]}, 32'b11110000);
    chk("r8_idle_active", {31'd0, act0},  32'd0);
    chk("r8_idle_clk",    {31'd0, dclk0}, 32'd0);
    step(); step();
    chk("r8_idle_hold", {29'd0, act0, dclk0, tick0}, 32'd0);
    en = 1'b1;
    step();
    chk("r8_restart", {29'd0, act0, dclk0, tick0}, 32'b111);

    // Ratios 0 and 1 keep the block idle
    en = 1'b0;
    len = 0;
    while (act0 && len < 20) begin
      step();
      len++;
    end
    chk("stop_idle", {31'd0, act0}, 32'd0);
    ratio = 8'd0; en = 1'b1;
    capture(6, c0, c1, t0);
    chk("r0_tick",   {16'd0, t0}, 32'd0);
    chk("r0_active", {31'd0, act0}, 32'd0);
    ratio = 8'd1;
    capture(6, c0, c1, t0);
    chk("r1_tick",   {16'd0, t0}, 32'd0);
    chk("r1_active", {31'd0, act0}, 32'd0);

    // Largest ratio: full counter range without wrap
    ratio = 8'd255;
    step();
    chk("r255_tick", {31'd0, tick0}, 32'd1);
    hi0 = 0; hi1 = 0; len = 0;
    do begin
      hi0 += int'(dclk0);
      hi1 += int'(dclk1);
      len++;
      step();
    end while (!tick0 && len < 300);
    chk("r255_len",   len, 32'd255);
    chk("r255_floor", hi0, 32'd127);
    chk("r255_ceil",  hi1, 32'd128);
    chk("r255_wrap",  {30'd0, dclk0, tick0}, 32'b11);

    // Reset pulse at cnt=3 of a 10-period
    ratio = 8'd10;
    sync_tick("r10_sync", 300);
    capture(3, c0, c1, t0);
    #2 rst_n = 1'b0;
    #1;
    chk("r10_rst_async", {21'd0, dclk0, tick0, act0, rcur0}, 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("r10_rel_idle", {31'd0, act0}, 32'd0);
    step();
    chk("r10_restart", {29'd0, act0, dclk0, tick0}, 32'b111);
    chk("r10_ratio",   {24'd0, rcur0}, 32'd10);
    capture(10, c0, c1, t0);
    chk("r10_clk", {22'd0, c0[9:0]}, 32'b1111100000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/param_clk_divider.md
PARAM_CLK_DIVIDER -- requirements
Module: param_clk_divider

Interface
REQ-001 Parameter DIV_WIDTH, default 8: width of ratio input, ratio shadow register and period counter.
REQ-002 Parameter DUTY_ROUND_UP, default 0: odd-ratio high phase; 0 = floor(R/2) cycles, 1 = ceil(R/2) cycles.
REQ-003 i_ref_clk  input  1  reference clock; all state on its rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_clk_en  input  1  run request; start and stop honoured only at period boundaries.
REQ-006 i_div_ratio  input  DIV_WIDTH  requested divide ratio R, unsigned.
REQ-007 o_div_clk  output  1  registered divided clock.
REQ-008 o_div_tick  output  1  one-cycle pulse coincident with each o_div_clk rising edge.
REQ-009 o_active  output  1  high while a divided period is in progress.
REQ-010 o_ratio_cur  output  DIV_WIDTH  ratio currently in effect (shadow register).

Function
REQ-011 States: IDLE (o_active=0) and RUN (o_active=1); o_active SHALL be a registered state bit.
REQ-012 Counter cnt SHALL be DIV_WIDTH bits, count 0..R_cur-1 in RUN, and never wrap for any R_cur up to 2^DIV_WIDTH-1.
REQ-013 High length H = R_cur>>1 if DUTY_ROUND_UP=0, else (R_cur+1)>>1; H computed at DIV_WIDTH+1 bits with no overflow.
REQ-014 In RUN, o_div_clk SHALL be 1 in cycles where cnt < H and 0 otherwise; o_div_clk registered together with cnt, no combinational path to the output.
REQ-015 Period boundary: RUN cycle with cnt == R_cur-1.
REQ-016 IDLE -> RUN: in IDLE with i_clk_en=1 and i_div_ratio>=2 at a clock edge, the same edge SHALL load R_cur=i_div_ratio, cnt=0, o_div_clk=1, o_div_tick=1, o_active=1.
REQ-017 At a period boundary with i_clk_en=1 and i_div_ratio>=2: load R_cur=i_div_ratio, cnt=0, o_div_clk=1, o_div_tick=1; stay in RUN.
REQ-018 At a period boundary with i_clk_en=0 or i_div_ratio<2: go to IDLE, cnt=0, o_div_clk=0, o_div_tick=0; R_cur keeps last value.
REQ-019 Mid-period changes of i_div_ratio or i_clk_en SHALL NOT alter the current period; no o_div_clk high or low phase shorter than its programmed length.
REQ-020 In IDLE: o_div_clk=0, o_div_tick=0, cnt=0; ratios 0 and 1 SHALL keep the block in IDLE.
REQ-021 o_div_tick SHALL be 0 in all cycles other than those in REQ-016/REQ-017.
REQ-022 Ratio 2 SHALL give 1 high, 1 low; ratio 3 with DUTY_ROUND_UP=0 SHALL give 1 high, 2 low, with DUTY_ROUND_UP=1 2 high, 1 low.

Reset
REQ-023 i_rst_n low SHALL immediately force o_div_clk=0, o_div_tick=0, o_active=0, cnt=0, o_ratio_cur=0, independent of clock.
REQ-024 Reset asserted mid-period SHALL abort the period; after release, restart only through REQ-016 at the first edge meeting its conditions.
REQ-025 Reset release SHALL be treated as synchronous to i_ref_clk; no output change before the first rising edge after release.

Verification
REQ-026 R=4, en=1 from reset release -> o_div_clk pattern 1100 repeating, tick every 4th cycle aligned with rising edge, o_active=1.
REQ-027 R=5, DUTY_ROUND_UP=0 then 1 -> 11000 and 11100 repeating, period 5 cycles.
REQ-028 R=6 running, i_div_ratio changed to 3 at cnt=2 -> current period completes as 111000, next period 100, o_ratio_cur updates at boundary only.
REQ-029 R=8 running, i_clk_en dropped at cnt=1 -> period finishes (11110000), then IDLE with o_div_clk=0, o_active=0; re-enable restarts with tick in the same edge.
REQ-030 i_div_ratio=0 and =1 with en=1 -> block stays IDLE, no ticks; DIV_WIDTH=8, R=255 -> 127 high, 128 low, counter reaches 254 and returns to 0 without wrap.
REQ-031 Reset pulse at cnt=3 of R=10 -> outputs zero asynchronously; after release, first period starts with cnt=0, o_div_clk=1.
